// File: rtl/cache_pkg.sv
// Shared types and address helpers for the N-way set-associative cache.
// Helpers take geometry as arguments so one package serves any instance size.
package cache_pkg;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } state_t;

  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned s_offset,
                                           input int unsigned s_index);
    return addr >> (s_offset + s_index);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned s_offset,
                                             input int unsigned s_index);
    return (addr >> s_offset) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                            input logic [31:0] index,
                                            input int unsigned s_offset,
                                            input int unsigned s_index);
    return (tag << (s_offset + s_index)) | (index << s_offset);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim lookup and post-access bit update.
// Node k has children 2k+1 / 2k+2; a 1 steers the victim to the upper half.
module plru_tree #(
  parameter int unsigned num_ways = 4,
  localparam int unsigned s_way = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] bits,
  input  logic [s_way-1:0]    way,
  input  logic                access,
  output logic [num_ways-2:0] next_bits,
  output logic [s_way-1:0]    victim
);

  logic [s_way-1:0] node_v;
  logic [s_way-1:0] node_a;

  always_comb begin
    victim = '0;
    node_v = '0;
    for (int l = 0; l < int'(s_way); l++) begin
      victim[s_way-1-l] = bits[node_v];
      node_v = s_way'(2 * int'(node_v) + 1 + int'(bits[node_v]));
    end
  end

  // Walk the accessed way's path, pointing every node at the opposite half.
  always_comb begin
    next_bits = bits;
    node_a    = '0;
    if (access) begin
      for (int l = 0; l < int'(s_way); l++) begin
        next_bits[node_a] = ~way[s_way-1-l];
        node_a = s_way'(2 * int'(node_a) + 1 + int'(way[s_way-1-l]));
      end
    end
  end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back, write-allocate cache with tree-PLRU replacement.
// Hits complete in the request cycle; misses optionally write back, then fill.
module nway_cache
  import cache_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 4,
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned s_mask   = 2 ** s_offset,
  parameter int unsigned s_line   = 8 * s_mask,
  parameter int unsigned s_way    = $clog2(num_ways)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_mask-1:0] mem_byte_enable,
  input  logic [s_line-1:0] mem_wdata,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned num_sets = 1 << s_index;

  logic [s_line-1:0]   data_q  [num_ways][num_sets];
  logic [s_tag-1:0]    tag_q   [num_ways][num_sets];
  logic [num_sets-1:0] valid_q [num_ways];
  logic [num_sets-1:0] dirty_q [num_ways];
  logic [num_ways-2:0] plru_q  [num_sets];

  state_t             state_q, state_d;
  logic [s_way-1:0]   victim_q, victim_d;
  logic [s_tag-1:0]   mtag_q, mtag_d;
  logic [s_index-1:0] midx_q, midx_d;

  logic [s_tag-1:0]    req_tag;
  logic [s_index-1:0]  req_idx;
  logic                request;
  logic [num_ways-1:0] hit_vec;
  logic                hit_any;
  logic [s_way-1:0]    hit_way;
  logic                have_inv;
  logic [s_way-1:0]    inv_way;
  logic [s_way-1:0]    plru_victim;
  logic [s_way-1:0]    victim_sel;
  logic [num_ways-2:0] plru_next;
  logic                plru_access;
  logic                fill_we;
  logic                hit_we;
  logic [s_line-1:0]   merged;

  assign req_tag = s_tag'(addr_tag(mem_address, s_offset, s_index));
  assign req_idx = s_index'(addr_index(mem_address, s_offset, s_index));
  assign request = mem_read | mem_write;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < num_ways; w++) begin
      hit_vec[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = s_way'(w);
    end
  end
  assign hit_any = |hit_vec;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    have_inv = 1'b0;
    inv_way  = '0;
    for (int w = int'(num_ways) - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        have_inv = 1'b1;
        inv_way  = s_way'(w);
      end
    end
  end

  assign plru_access = (state_q == CHECK) && request && hit_any;
  assign victim_sel  = have_inv ? inv_way : plru_victim;

  plru_tree #(
    .num_ways(num_ways)
  ) u_plru (
    .bits     (plru_q[req_idx]),
    .way      (hit_way),
    .access   (plru_access),
    .next_bits(plru_next),
    .victim   (plru_victim)
  );

  always_comb begin
    merged = data_q[hit_way][req_idx];
    for (int unsigned b = 0; b < s_mask; b++) begin
      if (mem_byte_enable[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata  = data_q[hit_way][req_idx];
  assign pmem_wdata = data_q[victim_q][midx_q];

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mtag_d       = mtag_q;
    midx_d       = midx_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    fill_we      = 1'b0;
    hit_we       = 1'b0;
    pmem_address = line_addr(32'(mtag_q), 32'(midx_q), s_offset, s_index);
    unique case (state_q)
      CHECK: begin
        if (request) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            hit_we   = mem_write;
          end else begin
            // Latch the miss so a changing or dropped request cannot disturb it.
            victim_d = victim_sel;
            mtag_d   = req_tag;
            midx_d   = req_idx;
            state_d  = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) ?
                       WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(32'(tag_q[victim_q][midx_q]), 32'(midx_q), s_offset, s_index);
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_we = 1'b1;
          state_d = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
      mtag_q   <= '0;
      midx_q   <= '0;
      for (int w = 0; w < int'(num_ways); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(num_sets); s++) plru_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      mtag_q   <= mtag_d;
      midx_q   <= midx_d;
      if (fill_we) begin
        valid_q[victim_q][midx_q] <= 1'b1;
        dirty_q[victim_q][midx_q] <= 1'b0;
      end
      if (hit_we) dirty_q[hit_way][req_idx] <= 1'b1;
      if (plru_access) plru_q[req_idx] <= plru_next;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[victim_q][midx_q] <= pmem_rdata;
      tag_q[victim_q][midx_q]  <= mtag_q;
    end else if (hit_we) begin
      data_q[hit_way][req_idx] <= merged;
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(hit_vec));

endmodule

// File: tb/tb_nway_cache.sv
// Directed bench for nway_cache: a set/way/PLRU model predicts pmem traffic and
// responses per request, and a negedge process checks the DUT against it.
module tb_nway_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  nway_cache dut (
    .clk            (clk),
    .rst            (rst),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory; untouched lines read as an address-derived pattern.
  logic [255:0] mem [int unsigned];

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  // Cache model: 16 sets x 4 ways, tree PLRU as 3 bits per set.
  logic [22:0]  m_tag   [16][4];
  bit           m_valid [16][4];
  bit           m_dirty [16][4];
  logic [255:0] m_data  [16][4];
  bit           m_plru  [16][3];

  localparam int K_NONE = 0;
  localparam int K_WB   = 1;
  localparam int K_RD   = 2;
  localparam int K_RESP = 3;

  int           exp_kind [4];
  logic [31:0]  exp_addr [4];
  logic [255:0] exp_data [4];
  int           exp_n   = 0;
  int           exp_pos = 0;
  int           last_victim;
  bit           chk_en = 1'b1;

  function automatic int plru_victim(input int s);
    int node, lo, span, half;
    node = 0; lo = 0; span = 4;
    while (span > 1) begin
      half = span / 2;
      if (m_plru[s][node]) begin
        lo   = lo + half;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
      span = half;
    end
    return lo;
  endfunction

  task automatic plru_touch(input int s, input int w);
    int node, lo, span, half;
    node = 0; lo = 0; span = 4;
    while (span > 1) begin
      half = span / 2;
      m_plru[s][node] = (w < lo + half);
      if (w >= lo + half) begin
        lo   = lo + half;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
      span = half;
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] a, input logic [255:0] d);
    exp_kind[exp_n] = k;
    exp_addr[exp_n] = a;
    exp_data[exp_n] = d;
    exp_n++;
  endtask

  task automatic model_access(input logic [31:0] a, input logic wr, input logic [31:0] be,
                              input logic [255:0] wd, input int delay, output int lat);
    int s, hw, v;
    logic [22:0]  t;
    logic [31:0]  la;
    logic [255:0] line;
    s = int'(a[8:5]);
    t = a[31:9];
    hw = -1;
    exp_n = 0;
    exp_pos = 0;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw < 0) begin
      lat = 1 + (delay + 1) + 1;
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = plru_victim(s);
      last_victim = v;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        la = {m_tag[s][v], a[8:5], 5'b0};
        push_exp(K_WB, la, m_data[s][v]);
        mem[la] = m_data[s][v];
        lat = lat + delay + 1;
      end
      la = {t, a[8:5], 5'b0};
      push_exp(K_RD, la, '0);
      m_data[s][v]  = mem_get(la);
      m_tag[s][v]   = t;
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      hw = v;
    end else begin
      lat = 1;
    end
    push_exp(K_RESP, '0, m_data[s][hw]);
    if (wr) begin
      line = m_data[s][hw];
      for (int b = 0; b < 32; b++) if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
      m_data[s][hw]  = line;
      m_dirty[s][hw] = 1'b1;
    end
    plru_touch(s, hw);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < 3; n++) m_plru[s][n] = 1'b0;
    end
  endtask

  int obs;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk32("strobe_excl", 32'(pmem_read & pmem_write), 32'd0);
      obs = pmem_write ? K_WB : pmem_read ? K_RD : mem_resp ? K_RESP : K_NONE;
      if (obs != K_NONE) begin
        if (exp_n == 0) begin
          chk32("unexpected_evt", obs, K_NONE);
        end else begin
          if (obs != exp_kind[exp_pos] && exp_pos + 1 < exp_n && obs == exp_kind[exp_pos+1])
            exp_pos++;
          chk32("evt_kind", obs, exp_kind[exp_pos]);
          if (obs == exp_kind[exp_pos]) begin
            if (obs != K_RESP) chk32("pmem_address", pmem_address, exp_addr[exp_pos]);
            if (obs == K_WB) chk256("pmem_wdata", pmem_wdata, exp_data[exp_pos]);
            if (obs == K_RESP) chk256("mem_rdata", mem_rdata, exp_data[exp_pos]);
          end
        end
      end
    end
  end

  bit           saw_wb, saw_rd, wb_first;
  logic [31:0]  wb_addr_seen, rd_addr_seen;
  logic [255:0] wb_data_seen, last_rdata;
  int           addr_changes;

  // Issue one request at posedge+1, play memory with the given strobe delay.
  task automatic run_req(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] be, input logic [255:0] wd, input int delay,
                         output int cycles);
    int lat, wcnt;
    bit done, prev_strobe, prev_wr;
    logic [31:0] prev_addr;
    model_access(a, wr, be, wd, delay, lat);
    mem_address = a; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    cycles = 0; wcnt = 0; done = 0; prev_strobe = 0; prev_wr = 0; prev_addr = '0;
    saw_wb = 0; saw_rd = 0; wb_first = 0; addr_changes = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_resp) begin
        done = 1;
        last_rdata = mem_rdata;
      end else if (pmem_read || pmem_write) begin
        if (prev_strobe && prev_wr == pmem_write && pmem_address != prev_addr) addr_changes++;
        prev_strobe = 1; prev_wr = pmem_write; prev_addr = pmem_address;
        if (pmem_write && !saw_wb) begin
          saw_wb = 1; wb_addr_seen = pmem_address; wb_data_seen = pmem_wdata;
          wb_first = !saw_rd;
        end
        if (pmem_read && !saw_rd) begin
          saw_rd = 1; rd_addr_seen = pmem_address;
        end
        wcnt++;
        if (wcnt > delay) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? mem_get(pmem_address) : '0;
          wcnt = 0;
        end
      end else begin
        prev_strobe = 0;
      end
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (done) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (!done) begin
      chk32("req_timeout", 32'(done), 32'd1);
      mem_read = 1'b0; mem_write = 1'b0;
    end
    chk32("latency", cycles, lat);
    chk32("evt_all_seen", exp_pos, exp_n - 1);
    exp_n = 0;
  endtask

  int cyc;
  int k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    model_reset();
    mem[32'h40] = {32{8'hA5}};
    #12;
    chk32("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk32("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk32("rst_pmem_write", 32'(pmem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read, then hit.
    run_req(32'h40, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("cold_lat", cyc, 3);
    chk32("cold_no_wb", 32'(saw_wb), 32'd0);
    chk32("cold_rd_addr", rd_addr_seen, 32'h40);
    chk256("cold_data", last_rdata, {32{8'hA5}});
    run_req(32'h40, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("reread_lat", cyc, 1);
    chk32("reread_no_rd", 32'(saw_rd), 32'd0);

    // PLRU eviction in set 0.
    run_req(32'h000, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h200, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h400, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h600, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h000, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("plru_hit0_lat", cyc, 1);
    run_req(32'h800, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("plru_victim_way2", last_victim, 2);
    chk32("plru_800_lat", cyc, 3);
    run_req(32'h400, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("plru_400_miss_lat", cyc, 3);
    run_req(32'h000, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("plru_000_hit_lat", cyc, 1);

    // Write hit, then force dirty eviction of 0x000.
    run_req(32'h000, 1'b0, 1'b1, 32'h0000_000F, 256'hDEADBEEF, 0, cyc);
    chk32("wr_hit_lat", cyc, 1);
    run_req(32'h400, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h800, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'h600, 1'b1, 1'b0, '0, '0, 0, cyc);
    run_req(32'hA00, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("wb_victim_way0", last_victim, 0);
    chk32("wb_lat", cyc, 4);
    chk32("wb_seen", 32'(saw_wb), 32'd1);
    chk32("wb_before_rd", 32'(wb_first), 32'd1);
    chk32("wb_addr", wb_addr_seen, 32'h000);
    chk256("wb_merged", wb_data_seen, {{7{32'h5A5A_0F0F}}, 32'hDEADBEEF});
    chk32("wb_fill_addr", rd_addr_seen, 32'hA00);

    // Write miss allocates, merges, then reads back.
    run_req(32'h1000, 1'b0, 1'b1, 32'h0000_FF00, {32{8'h3C}}, 0, cyc);
    chk32("wmiss_lat", cyc, 3);
    chk32("wmiss_no_wb", 32'(saw_wb), 32'd0);
    run_req(32'h1000, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk256("wmiss_readback", last_rdata,
           {{4{32'h5A5A_1F0F}}, {2{32'h3C3C_3C3C}}, {2{32'h5A5A_1F0F}}});
    run_req(32'h1000, 1'b1, 1'b1, 32'h0000_0001, 256'h77, 0, cyc);
    chk32("rdwr_as_write_lat", cyc, 1);
    run_req(32'h1000, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("rdwr_byte0", 32'(last_rdata[7:0]), 32'h77);

    // Async reset in the middle of a fill.
    chk_en = 1'b0;
    mem_address = 32'h2000; mem_read = 1'b1;
    k = 0;
    while (!pmem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk32("abort_in_fill", 32'(pmem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk32("async_rst_pmem_read", 32'(pmem_read), 32'd0);
    chk32("async_rst_mem_resp", 32'(mem_resp), 32'd0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    run_req(32'h000, 1'b1, 1'b0, '0, '0, 0, cyc);
    chk32("post_rst_miss_lat", cyc, 3);
    chk32("post_rst_rd_addr", rd_addr_seen, 32'h000);

    // Slow memory.
    run_req(32'h3000, 1'b1, 1'b0, '0, '0, 10, cyc);
    chk32("slow_lat", cyc, 13);
    chk32("slow_addr_stable", addr_changes, 0);
    chk32("slow_rd_addr", rd_addr_seen, 32'h3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nway_cache.md
Name: nway_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache: datapath and control in one block.
- Sits between the CPU-side line interface (256-bit line, byte-enabled) and physical memory (pmem, burst-line interface).
- Generalises the fixed 4-way read-only datapath: way count and geometry are parameters, plus dirty tracking, write-back, tree-PLRU replacement and an owning FSM.

Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes.
- s_index, 4, set-index bits; num_sets = 2**s_index.
- num_ways, 4, associativity; power of two, >= 2.
- s_tag, 32-s_offset-s_index, tag width (derived).
- s_mask, 2**s_offset, byte-enable width (derived).
- s_line, 8*s_mask, line width in bits (derived).
- s_way, $clog2(num_ways), way-index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_address  in  32  CPU byte address; only line bits are used
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  s_mask  write byte mask
- mem_wdata  in  s_line  write line data
- mem_rdata  out  s_line  hit line data; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned memory address
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line write-back request, held until pmem_resp
- pmem_wdata  out  s_line  victim line data
- pmem_rdata  in  s_line  fill data, valid with pmem_resp
- pmem_resp  in  1  memory completion

Behaviour:
- Storage: per way, flop arrays of data[num_sets], tag[num_sets], valid[num_sets] and dirty[num_sets]. Reads are combinational on the index; writes take effect at the clk rising edge. Per set, num_ways-1 PLRU bits.
- Reset (async, rst=1):
  - valid, dirty and PLRU bits are cleared; state goes to CHECK.
  - mem_resp, pmem_read and pmem_write are 0 immediately.
  - Data and tag contents are undefined after reset.
- Address split: tag = [31:s_offset+s_index], index = [s_offset+s_index-1:s_offset].
- Hit: valid & tag match in any way. At most one way hits; a multi-hit is an assertion failure.
- FSM states: CHECK, WRITEBACK, FILL.
- CHECK, no request: all outputs idle.
- CHECK, request and hit:
  - mem_resp=1 combinationally in that same cycle (0-cycle hit latency); mem_rdata = hit way data.
  - Write hit: at the edge, bytes with byte_enable=1 are merged into the line and dirty is set. mem_rdata shows the pre-merge line.
  - PLRU of the set is updated toward the hit way.
- CHECK, request and miss:
  - Victim = lowest-numbered invalid way; if all ways are valid, victim = PLRU way.
  - Victim valid & dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp -> FILL.
- FILL:
  - pmem_read=1; pmem_address = {req tag, index, 0}.
  - On pmem_resp: victim data <= pmem_rdata, tag <= req tag, valid <= 1, dirty <= 0, then -> CHECK.
  - Next cycle the request hits and is served as a normal hit; PLRU updates only there.
- Miss latency: (WB cycles) + (fill cycles) + 1.
- pmem_address and pmem_wdata are held stable while a pmem strobe is high. pmem_read and pmem_write are never high together.
- Tree PLRU:
  - Bit 0 is the root; node k has children 2k+1 and 2k+2. A bit value of 1 means the next victim lies in the upper half.
  - On an access to way w, every node on the path is set to point away from w.
  - Victim selection follows the bits from the root. Reset state -> victim way 0.
- Request rules:
  - Requester keeps address, data and strobes stable until mem_resp.
  - mem_read & mem_write together: treated as a write.
  - pmem_resp outside WRITEBACK/FILL is ignored.
  - A request dropped mid-miss still completes the fill; no mem_resp is issued unless the request is present in CHECK.

Decomposition:
- Package cache_pkg: state enum (CHECK, WRITEBACK, FILL) and helper functions for tag/index extraction and line-address build.
- Sub-module plru_tree (parameter num_ways): purely combinational.
  - Inputs: current bits, access way, access strobe.
  - Outputs: next bits, victim way.
  - Instantiated once on the indexed set's bits.

Test Plan:
1. Cold read:
   - After reset, read 0x0000_0040 -> pmem_read, pmem_address=0x40, no pmem_write.
   - pmem_rdata=0xA5..A5 -> mem_resp 1 cycle after pmem_resp, mem_rdata=0xA5..A5.
   - Re-read -> mem_resp in the request cycle, no pmem activity.
2. PLRU eviction (defaults):
   - Read 0x000, 0x200, 0x400, 0x600 (ways 0-3), then 0x000 (hit).
   - Read 0x800 -> fill into way 2, replacing 0x400. A later 0x400 read misses; 0x000 hits.
3. Write hit then dirty eviction:
   - Write 0x000 with byte_enable=0x0000000F, wdata bytes 0-3 = 0xDEADBEEF.
   - Force 0x000's eviction -> pmem_write at 0x000 with the merged line, before the pmem_read of the new address.
4. Write miss (write-allocate):
   - Write to uncached 0x1000 -> FILL, then merge, then mem_resp; dirty=1.
   - Subsequent read returns the merged data.
5. Async reset mid-FILL:
   - rst asserted while pmem_read=1 -> pmem_read drops without waiting for clk.
   - After release, a read of the previously cached 0x000 misses.
6. Slow memory:
   - pmem_resp delayed 10 cycles -> pmem_read and pmem_address stay stable, mem_resp stays 0 until completion.
